bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder_if.sv | 22 ++
 rtl/bus_mem_responder.sv | 90 +++++++++
 tb/tb_bus_mem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// Word-addressed memory bus between one master and the bus_mem_responder.
// Handshake: the master raises W_CLK with W_ADDR/W_WRITE/W_DATA_O stable and holds it
// until it sees the one-cycle W_ACK pulse; W_ERR and W_DATA_I are meaningful only while W_ACK=1.
interface bus_mem_responder_if;
   logic        W_CLK;
   logic [31:0] W_ADDR;
   logic        W_WRITE;
   logic [31:0] W_DATA_O;
   logic [31:0] W_DATA_I;
   logic        W_ACK;
   logic        W_ERR;

   modport master (
      output W_CLK, W_ADDR, W_WRITE, W_DATA_O,
      input  W_DATA_I, W_ACK, W_ERR
   );

   modport slave (
      input  W_CLK, W_ADDR, W_WRITE, W_DATA_O,
      output W_DATA_I, W_ACK, W_ERR
   );
endinterface

// File: rtl/bus_mem_responder.sv
// Single-port 32-bit memory responder: capture a strobed request, wait a fixed number
// of cycles, perform one access, pulse ACK, then wait for the strobe to drop.
module bus_mem_responder #(
   parameter int unsigned AW          = 8,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [32:0] LIMIT       = 33'(1) << AW
) (
   input  logic                  clk,
   input  logic                  W_RST,
   bus_mem_responder_if.slave    bus,
   output logic [2:0]            o_dbg_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_ACCESS  = 3'd2;
   localparam logic [2:0] S_ACK     = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [2:0]  r_state;
   logic [3:0]  r_wait_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_write;
   logic [31:0] r_rdata;
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_mem [0:(1 << AW) - 1];

   logic          w_in_range;
   logic [AW-1:0] w_idx;

   // Full 32-bit compare: high addresses never alias onto low memory words.
   assign w_in_range = ({1'b0, r_addr} < LIMIT);
   assign w_idx      = r_addr[AW-1:0];

   always_ff @(posedge clk or negedge W_RST) begin
      if (!W_RST) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= 4'd0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_write    <= 1'b0;
         r_rdata    <= 32'd0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.W_CLK) begin
                  r_addr     <= bus.W_ADDR;
                  r_write    <= bus.W_WRITE;
                  r_wdata    <= bus.W_DATA_O;
                  r_wait_cnt <= WAIT_LOAD;
                  r_state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               if (r_wait_cnt == 4'd0) r_state <= S_ACCESS;
               else                    r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            S_ACCESS: begin
               if (!w_in_range)  r_rdata <= 32'h0;
               else if (!r_write) r_rdata <= r_mem[w_idx];
               r_ack   <= 1'b1;
               r_err   <= !w_in_range;
               r_state <= S_ACK;
            end
            S_ACK: r_state <= S_RELEASE;
            // Holding here until the strobe drops stops a held request being served twice.
            S_RELEASE: if (!bus.W_CLK) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_ACCESS && r_write && w_in_range) r_mem[w_idx] <= r_wdata;
   end

   assign bus.W_DATA_I = r_rdata;
   assign bus.W_ACK    = r_ack;
   assign bus.W_ERR    = r_err;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: one instance with WAIT_CYCLES=2, one with 0.
module tb_bus_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_mem_responder_if if2();
  bus_mem_responder_if if0();
  logic [2:0] st2, st0;

  bus_mem_responder #(.AW(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .W_RST(rst_n), .bus(if2.slave), .o_dbg_state(st2));
  bus_mem_responder #(.AW(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .W_RST(rst_n), .bus(if0.slave), .o_dbg_state(st0));

  int tests = 0;
  int fails = 0;
  int sel = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mdl_mem [2][256];
  logic [31:0] mdl_last [2];

  function automatic logic g_ack();
    return (sel == 0) ? if2.W_ACK : if0.W_ACK;
  endfunction
  function automatic logic g_err();
    return (sel == 0) ? if2.W_ERR : if0.W_ERR;
  endfunction
  function automatic logic [31:0] g_data();
    return (sel == 0) ? if2.W_DATA_I : if0.W_DATA_I;
  endfunction
  function automatic logic [2:0] g_state();
    return (sel == 0) ? st2 : st0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic stb, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      if2.W_CLK = stb; if2.W_WRITE = wr; if2.W_ADDR = a; if2.W_DATA_O = d;
    end else begin
      if0.W_CLK = stb; if0.W_WRITE = wr; if0.W_ADDR = a; if0.W_DATA_O = d;
    end
  endtask

  // Drive a request and push the response the model predicts for it.
  task automatic start(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d);
    sel = s;
    if (a >= 32'd256) begin
      mdl_last[s] = 32'h0;
      exp_q.push_back({1'b1, 32'h0});
    end else if (wr) begin
      exp_q.push_back({1'b0, mdl_last[s]});
      mdl_mem[s][a[7:0]] = d;
    end else begin
      mdl_last[s] = mdl_mem[s][a[7:0]];
      exp_q.push_back({1'b0, mdl_last[s]});
    end
    set_bus(1'b1, wr, a, d);
  endtask

  task automatic wait_ack(input string tag, input int lat);
    int n;
    logic [32:0] e;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (g_ack()) break;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check({tag, " data"}, 64'(g_data()), 64'(e[31:0]));
    check({tag, " err"}, 64'(g_err()), 64'(e[32]));
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check({tag, " ack one cycle"}, 64'(g_ack()), 64'd0);
    @(negedge clk);
    check({tag, " back to idle"}, 64'(g_state()), 64'd0);
  endtask

  initial begin
    int acks;
    logic [31:0] a, d;
    rst_n = 1'b0;
    mdl_last[0] = 32'h0;
    mdl_last[1] = 32'h0;
    sel = 1; set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    sel = 0; set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      check("reset data", 64'(g_data()), 64'd0);
      check("reset ack", 64'(g_ack()), 64'd0);
      check("reset err", 64'(g_err()), 64'd0);
      check("reset state", 64'(g_state()), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read, WAIT_CYCLES=2
    start(0, 1'b1, 32'd5, 32'hCAFE_0001); wait_ack("wr5", 4);
    start(0, 1'b0, 32'd5, 32'h0);         wait_ack("rd5", 4);

    // WAIT_CYCLES=0, back-to-back at minimum spacing
    start(1, 1'b1, 32'd0, 32'hA0A0_0000); wait_ack("w0 wr0", 2);
    start(1, 1'b1, 32'd1, 32'hA1A1_0001); wait_ack("w0 wr1", 2);
    start(1, 1'b0, 32'd0, 32'h0);         wait_ack("w0 rd0", 2);
    start(1, 1'b0, 32'd1, 32'h0);         wait_ack("w0 rd1", 2);

    // Out of range and no aliasing of high addresses
    start(0, 1'b1, 32'd0, 32'h0000_1111);   wait_ack("wr0", 4);
    start(0, 1'b0, 32'd5, 32'h0);           wait_ack("rd5 again", 4);
    start(0, 1'b1, 32'd256, 32'h0000_1234); wait_ack("wr256", 4);
    start(0, 1'b0, 32'd256, 32'h0);         wait_ack("rd256", 4);
    start(0, 1'b0, 32'd0, 32'h0);           wait_ack("rd0 kept", 4);
    start(0, 1'b1, 32'h0000_0105, 32'h5555_5555); wait_ack("wr 0x105", 4);
    start(0, 1'b0, 32'h8000_0005, 32'h0);   wait_ack("rd high", 4);
    start(0, 1'b0, 32'd5, 32'h0);           wait_ack("rd5 no alias", 4);

    // Strobe held for 20 cycles gives exactly one ACK
    sel = 0;
    mdl_last[0] = mdl_mem[0][5];
    set_bus(1'b1, 1'b0, 32'd5, 32'h0);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (g_ack()) begin
        acks++;
        check("held data", 64'(g_data()), 64'(mdl_mem[0][5]));
      end
    end
    check("held ack count", 64'(acks), 64'd1);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("held released", 64'(g_state()), 64'd0);

    // Strobe dropped right after capture still completes
    start(0, 1'b1, 32'd10, 32'h0BAD_0010);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    wait_ack("early drop", 3);
    start(0, 1'b0, 32'd10, 32'h0); wait_ack("rd10", 4);

    // Inputs changed during WAIT do not affect the captured write
    start(0, 1'b1, 32'd9, 32'h0000_9999); wait_ack("wr9", 4);
    start(0, 1'b1, 32'd7, 32'h0000_7777);
    @(negedge clk);
    set_bus(1'b1, 1'b1, 32'd9, 32'hDEAD_BEEF);
    wait_ack("wr7 changed", 3);
    start(0, 1'b0, 32'd7, 32'h0); wait_ack("rd7", 4);
    start(0, 1'b0, 32'd9, 32'h0); wait_ack("rd9", 4);

    // Reset during WAIT aborts the write
    start(0, 1'b1, 32'd3, 32'h0000_3333); wait_ack("wr3", 4);
    sel = 0;
    set_bus(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    check("abort in wait", 64'(g_state()), 64'd1);
    rst_n = 1'b0;
    mdl_last[0] = 32'h0;
    mdl_last[1] = 32'h0;
    #1;
    check("abort ack", 64'(g_ack()), 64'd0);
    check("abort state", 64'(g_state()), 64'd0);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (g_ack()) acks++;
    end
    check("abort no ack", 64'(acks), 64'd0);
    start(0, 1'b0, 32'd3, 32'h0); wait_ack("rd3 kept", 4);

    // Strobe already high when reset releases is served at once
    rst_n = 1'b0;
    mdl_last[0] = 32'h0;
    mdl_last[1] = 32'h0;
    start(1, 1'b0, 32'd1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack("strobe at reset exit", 2);

    // Random in-range write/read pairs
    repeat (6) begin
      a = 32'($urandom_range(20, 255));
      d = $urandom;
      start(0, 1'b1, a, d);         wait_ack("rand wr", 4);
      start(0, 1'b0, a, 32'h0);     wait_ack("rand rd", 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
